// File: rtl/mmu_pkg.sv
// mmu_pkg: shared definitions for the MMU activation feeder.
//   DATA_WIDTH_DEFAULT : default activation width (matches PE input)
//   ROWS_DEFAULT       : default array row count
//   skew_state_t       : feeder FSM states {IDLE, STREAM, DRAIN}
//   drain_cnt_width()  : width of a counter that must hold ROWS-1
package mmu_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;
  localparam int ROWS_DEFAULT       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_t;

  // At least one bit so ROWS=1 still yields a legal vector.
  function automatic int drain_cnt_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/mmu_act_skew_if.sv
// mmu_act_skew_if: row-vector input handshake of the activation feeder.
//   in_valid : vector present                      (master -> slave)
//   in_last  : vector is last of its stream         (master -> slave)
//   in_data  : ROWS lanes of DATA_WIDTH, lane r at [r*DATA_WIDTH +: DATA_WIDTH]
//   in_ready : feeder can accept                    (slave -> master)
interface mmu_act_skew_if
  import mmu_pkg::*;
#(
  parameter int ROWS       = ROWS_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

  logic                       in_valid;
  logic                       in_ready;
  logic                       in_last;
  logic [ROWS*DATA_WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_last,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/mmu_skew_delay.sv
// mmu_skew_delay: one skew lane, a DEPTH-stage shift register of {valid, data}.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-high (clears every stage)
//   valid_in  : stage-0 valid (the top's accept)
//   data_in   : stage-0 data (one activation lane)
//   valid_out : last-stage valid -> PE row enable
//   data_out  : last-stage data  -> PE row activation
// Build option MMU_ACT_SKEW_ZERO_FILL_EN: bubble stages carry zero data.
// Without it, data only advances behind a valid, so every stage (and the
// output) keeps the last valid activation it saw during bubbles.
module mmu_skew_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  logic [DEPTH-1:0]            valid_reg;
  logic [DEPTH-1:0][WIDTH-1:0] data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      data_reg  <= '0;
    end else begin
      valid_reg[0] <= valid_in;
`ifdef MMU_ACT_SKEW_ZERO_FILL_EN
      data_reg[0] <= valid_in ? data_in : '0;
`else
      if (valid_in) data_reg[0] <= data_in;
`endif
      for (int i = 1; i < DEPTH; i++) begin
        valid_reg[i] <= valid_reg[i-1];
`ifdef MMU_ACT_SKEW_ZERO_FILL_EN
        data_reg[i] <= valid_reg[i-1] ? data_reg[i-1] : '0;
`else
        if (valid_reg[i-1]) data_reg[i] <= data_reg[i-1];
`endif
      end
    end
  end

  assign valid_out = valid_reg[DEPTH-1];
  assign data_out  = data_reg[DEPTH-1];

endmodule

// File: rtl/mmu_act_skew.sv
// mmu_act_skew: activation feeder for the MMU systolic array.
// Accepts one ROWS-lane vector per cycle and re-times it into a diagonal
// wavefront: lane r appears on PE row r exactly r+1 cycles after accept,
// with its own enable. done pulses when the last activation of a stream
// reaches row ROWS-1.
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active-high
//   in_if   : mmu_act_skew_if.slave (in_valid, in_ready, in_last, in_data)
//   act_out : skewed activations, lane r -> PE row r
//   en_out  : per-row enable, bit r -> PE row r
//   busy    : stream in progress (state != IDLE)
//   done    : one-cycle pulse coinciding with the final en_out[ROWS-1]
// Build option MMU_ACT_SKEW_ZERO_FILL_EN: act_out lane is 0 whenever its
// enable is 0; otherwise the lane holds its last enabled value.
module mmu_act_skew
  import mmu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ROWS       = ROWS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  mmu_act_skew_if.slave              in_if,
  output logic [ROWS*DATA_WIDTH-1:0] act_out,
  output logic [ROWS-1:0]            en_out,
  output logic                       busy,
  output logic                       done
);

  localparam int              CNT_W    = drain_cnt_width(ROWS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  skew_state_t      state_reg;
  logic [CNT_W-1:0] drain_cnt_reg;
  logic             done_reg;
  logic             busy_reg;
  logic             accept;

  // The skew lines never stall, so the only reason to refuse input is the
  // drain window (and reset).
  assign in_if.in_ready = (state_reg != DRAIN) && !rst;
  assign accept         = in_if.in_valid && in_if.in_ready;

  // done is registered: it is raised one cycle early, when the counter is
  // about to hit zero, or immediately on the last accept when ROWS==1
  // (the drain window is then a single cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= '0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, STREAM: begin
          if (accept) begin
            busy_reg <= 1'b1;
            if (in_if.in_last) begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= CNT_LOAD;
              done_reg      <= (ROWS == 1);
            end else begin
              state_reg <= STREAM;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - CNT_ONE;
            done_reg      <= (drain_cnt_reg == CNT_ONE);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign done = done_reg;
  assign busy = busy_reg;

  // Lane r gets r+1 stages so accept at t shows on row r in cycle t+1+r.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_lane
      mmu_skew_delay #(
        .DEPTH (gi + 1),
        .WIDTH (DATA_WIDTH)
      ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (accept),
        .data_in   (in_if.in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .valid_out (en_out[gi]),
        .data_out  (act_out[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mmu_act_skew.sv
// tb_mmu_act_skew: directed bench for mmu_act_skew.
// Instance a: ROWS=4, DATA_WIDTH=16. Instance b: ROWS=1, DATA_WIDTH=16.
// Inputs change on the falling edge; outputs are sampled there too.
// Expected act_out tables follow MMU_ACT_SKEW_ZERO_FILL_EN when defined.
module tb_mmu_act_skew;

  logic clk;
  logic rst;

  logic [63:0] act_a;
  logic [3:0]  en_a;
  logic        busy_a, done_a;
  logic [15:0] act_b;
  logic [0:0]  en_b;
  logic        busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  mmu_act_skew_if #(.ROWS(4), .DATA_WIDTH(16)) if_a ();
  mmu_act_skew_if #(.ROWS(1), .DATA_WIDTH(16)) if_b ();

  mmu_act_skew #(.DATA_WIDTH(16), .ROWS(4)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .in_if   (if_a),
    .act_out (act_a),
    .en_out  (en_a),
    .busy    (busy_a),
    .done    (done_a)
  );

  mmu_act_skew #(.DATA_WIDTH(16), .ROWS(1)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .in_if   (if_b),
    .act_out (act_b),
    .en_out  (en_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] v4(input logic [15:0] l3, input logic [15:0] l2,
                                     input logic [15:0] l1, input logic [15:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Expected tables
  logic [3:0]  en1   [5];
  logic [63:0] act1  [5];
  logic [3:0]  en2   [8];
  logic [63:0] act2  [8];
  logic        done2 [8];
  logic        rdy2  [8];
  logic        busy2 [8];
  logic [3:0]  en3   [10];
  logic        done3 [10];
  logic        rdy3  [10];

  initial begin
    en1  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
`ifdef MMU_ACT_SKEW_ZERO_FILL_EN
    act1 = '{v4(0,0,0,16'h11), v4(0,0,16'h22,0), v4(0,16'h33,0,0),
             v4(16'h44,0,0,0), 64'h0};
`else
    act1 = '{v4(0,0,0,16'h11), v4(0,0,16'h22,16'h11), v4(0,16'h33,16'h22,16'h11),
             v4(16'h44,16'h33,16'h22,16'h11), v4(16'h44,16'h33,16'h22,16'h11)};
`endif
    en2   = '{4'b0001, 4'b0010, 4'b0101, 4'b1011, 4'b0110, 4'b1100, 4'b1000, 4'b0000};
    done2 = '{0, 0, 0, 0, 0, 0, 1, 0};
    rdy2  = '{1, 1, 1, 0, 0, 0, 0, 1};
    busy2 = '{1, 1, 1, 1, 1, 1, 1, 0};
`ifdef MMU_ACT_SKEW_ZERO_FILL_EN
    act2 = '{64'h0, v4(0,0,16'h01,0), v4(0,16'h02,0,16'h10),
             v4(16'h03,0,16'h11,16'h20), v4(0,16'h12,16'h21,0),
             v4(16'h13,16'h22,0,0), v4(16'h23,0,0,0), 64'h0};
`else
    act2 = '{v4(16'h44,16'h33,16'h22,16'h00), v4(16'h44,16'h33,16'h01,16'h00),
             v4(16'h44,16'h02,16'h01,16'h10), v4(16'h03,16'h02,16'h11,16'h20),
             v4(16'h03,16'h12,16'h21,16'h20), v4(16'h13,16'h22,16'h21,16'h20),
             v4(16'h23,16'h22,16'h21,16'h20), v4(16'h23,16'h22,16'h21,16'h20)};
`endif
    // Scenario 3: A accepted at c0, B held and accepted at c5.
    en3   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
              4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    done3 = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    rdy3  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  end

  initial begin
    rst         = 1'b1;
    if_a.in_valid = 1'b0;
    if_a.in_last  = 1'b0;
    if_a.in_data  = '0;
    if_b.in_valid = 1'b0;
    if_b.in_last  = 1'b0;
    if_b.in_data  = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_en",    64'(en_a),          64'h0);
    check("rst_act",   act_a,              64'h0);
    check("rst_busy",  64'(busy_a),        64'h0);
    check("rst_done",  64'(done_a),        64'h0);
    check("rst_ready", 64'(if_a.in_ready), 64'h0);
    $display("reset: en=%b act=%h busy=%b done=%b ready=%b", en_a, act_a, busy_a, done_a, if_a.in_ready);
    rst = 1'b0;

    // ---------------- single-vector stream ----------------
    @(negedge clk);
    check("s1_ready_c0", 64'(if_a.in_ready), 64'h1);
    if_a.in_valid = 1'b1;
    if_a.in_last  = 1'b1;
    if_a.in_data  = v4(16'h44, 16'h33, 16'h22, 16'h11);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if_a.in_valid = 1'b0;
        if_a.in_last  = 1'b0;
      end
      check($sformatf("s1_en_c%0d", c),    64'(en_a),          64'(en1[c-1]));
      check($sformatf("s1_act_c%0d", c),   act_a,              act1[c-1]);
      check($sformatf("s1_done_c%0d", c),  64'(done_a),        64'(c == 4));
      check($sformatf("s1_ready_c%0d", c), 64'(if_a.in_ready), 64'(c == 5));
      $display("s1 c%0d: en=%b act=%h done=%b ready=%b", c, en_a, act_a, done_a, if_a.in_ready);
    end

    // ---------------- 3-vector stream with a bubble ----------------
    @(negedge clk);
    if_a.in_valid = 1'b1;
    if_a.in_last  = 1'b0;
    if_a.in_data  = v4(16'h03, 16'h02, 16'h01, 16'h00);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      case (c)
        1: if_a.in_valid = 1'b0;
        2: begin
          if_a.in_valid = 1'b1;
          if_a.in_data  = v4(16'h13, 16'h12, 16'h11, 16'h10);
        end
        3: begin
          if_a.in_data = v4(16'h23, 16'h22, 16'h21, 16'h20);
          if_a.in_last = 1'b1;
        end
        4: begin
          if_a.in_valid = 1'b0;
          if_a.in_last  = 1'b0;
        end
        default: ;
      endcase
      check($sformatf("s2_en_c%0d", c),    64'(en_a),          64'(en2[c-1]));
      check($sformatf("s2_act_c%0d", c),   act_a,              act2[c-1]);
      check($sformatf("s2_done_c%0d", c),  64'(done_a),        64'(done2[c-1]));
      check($sformatf("s2_ready_c%0d", c), 64'(if_a.in_ready), 64'(rdy2[c-1]));
      check($sformatf("s2_busy_c%0d", c),  64'(busy_a),        64'(busy2[c-1]));
      $display("s2 c%0d: en=%b act=%h done=%b ready=%b busy=%b", c, en_a, act_a, done_a, if_a.in_ready, busy_a);
    end

    // ---------------- in_valid held high through DRAIN ----------------
    @(negedge clk);
    if_a.in_valid = 1'b1;
    if_a.in_last  = 1'b1;
    if_a.in_data  = v4(16'hA3, 16'hA2, 16'hA1, 16'hA0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) if_a.in_data = v4(16'hB3, 16'hB2, 16'hB1, 16'hB0);
      if (c == 6) begin
        if_a.in_valid = 1'b0;
        if_a.in_last  = 1'b0;
      end
      check($sformatf("s3_en_c%0d", c),    64'(en_a),          64'(en3[c-1]));
      check($sformatf("s3_done_c%0d", c),  64'(done_a),        64'(done3[c-1]));
      check($sformatf("s3_ready_c%0d", c), 64'(if_a.in_ready), 64'(rdy3[c-1]));
      if (c == 6) check("s3_b_lane0", 64'(act_a[15:0]), 64'hB0);
      $display("s3 c%0d: en=%b act=%h done=%b ready=%b", c, en_a, act_a, done_a, if_a.in_ready);
    end

    // ---------------- reset mid-stream ----------------
    @(negedge clk);
    if_a.in_valid = 1'b1;
    if_a.in_last  = 1'b0;
    if_a.in_data  = v4(16'hC3, 16'hC2, 16'hC1, 16'hC0);
    @(negedge clk);
    if_a.in_data = v4(16'hD3, 16'hD2, 16'hD1, 16'hD0);
    check("s4_en_c1",   64'(en_a),   64'h1);
    check("s4_busy_c1", 64'(busy_a), 64'h1);
    $display("s4 c1: en=%b busy=%b", en_a, busy_a);
    @(negedge clk);
    rst = 1'b1;
    if_a.in_valid = 1'b0;
    #1;
    check("s4_rst_en",    64'(en_a),          64'h0);
    check("s4_rst_act",   act_a,              64'h0);
    check("s4_rst_busy",  64'(busy_a),        64'h0);
    check("s4_rst_done",  64'(done_a),        64'h0);
    check("s4_rst_ready", 64'(if_a.in_ready), 64'h0);
    $display("s4 rst: en=%b act=%h busy=%b done=%b ready=%b", en_a, act_a, busy_a, done_a, if_a.in_ready);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("s4_en_c%0d", c),    64'(en_a),          64'h0);
      check($sformatf("s4_done_c%0d", c),  64'(done_a),        64'h0);
      check($sformatf("s4_busy_c%0d", c),  64'(busy_a),        64'h0);
      check($sformatf("s4_ready_c%0d", c), 64'(if_a.in_ready), 64'h1);
      $display("s4 c%0d: en=%b done=%b busy=%b ready=%b", c, en_a, done_a, busy_a, if_a.in_ready);
    end

    // ---------------- ROWS=1 back-to-back single-vector streams ----------------
    @(negedge clk);
    check("s5_ready_c0", 64'(if_b.in_ready), 64'h1);
    if_b.in_valid = 1'b1;
    if_b.in_last  = 1'b1;
    if_b.in_data  = 16'h0101;
    @(negedge clk);
    if_b.in_data = 16'h0202;
    check("s5_en_c1",    64'(en_b),          64'h1);
    check("s5_act_c1",   64'(act_b),         64'h0101);
    check("s5_done_c1",  64'(done_b),        64'h1);
    check("s5_ready_c1", 64'(if_b.in_ready), 64'h0);
    $display("s5 c1: en=%b act=%h done=%b ready=%b", en_b, act_b, done_b, if_b.in_ready);
    @(negedge clk);
    check("s5_en_c2",    64'(en_b),          64'h0);
    check("s5_done_c2",  64'(done_b),        64'h0);
    check("s5_ready_c2", 64'(if_b.in_ready), 64'h1);
`ifdef MMU_ACT_SKEW_ZERO_FILL_EN
    check("s5_act_c2",   64'(act_b),         64'h0);
`else
    check("s5_act_c2",   64'(act_b),         64'h0101);
`endif
    $display("s5 c2: en=%b act=%h done=%b ready=%b", en_b, act_b, done_b, if_b.in_ready);
    @(negedge clk);
    if_b.in_valid = 1'b0;
    if_b.in_last  = 1'b0;
    check("s5_en_c3",    64'(en_b),          64'h1);
    check("s5_act_c3",   64'(act_b),         64'h0202);
    check("s5_done_c3",  64'(done_b),        64'h1);
    check("s5_ready_c3", 64'(if_b.in_ready), 64'h0);
    $display("s5 c3: en=%b act=%h done=%b ready=%b", en_b, act_b, done_b, if_b.in_ready);
    @(negedge clk);
    check("s5_en_c4",    64'(en_b),          64'h0);
    check("s5_done_c4",  64'(done_b),        64'h0);
    check("s5_ready_c4", 64'(if_b.in_ready), 64'h1);
    $display("s5 c4: en=%b done=%b ready=%b", en_b, done_b, if_b.in_ready);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
